// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-memory access sizes, controller states and RAM geometry.
package cpu_pkg;

    localparam int MEM_ADDR_W = 17;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

    // Encoding 3 is treated as a word so every request size is legal.
    function automatic mem_size_t decode_size(input logic [1:0] raw);
        case (raw)
            2'd0:    return BYTE;
            2'd1:    return HALF;
            default: return WORD;
        endcase
    endfunction

    function automatic logic [1:0] last_index(input mem_size_t size);
        case (size)
            BYTE:    return 2'd0;
            HALF:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational byte-assembly and sign/zero-extension of little-endian load data.
module load_ext
    import cpu_pkg::*;
(
    input  logic [31:0] bytes_in,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic fill;

    always_comb begin
        result = bytes_in;
        fill   = 1'b0;
        case (size)
            BYTE: begin
                fill   = ~is_unsigned & bytes_in[7];
                result = {{24{fill}}, bytes_in[7:0]};
            end
            HALF: begin
                fill   = ~is_unsigned & bytes_in[15];
                result = {{16{fill}}, bytes_in[15:0]};
            end
            default: result = bytes_in;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Serialises one load/store at a time into byte accesses on a byte-wide synchronous RAM,
// stalling the pipeline while the access is in flight.
module mem_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ex_signal,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);

    mem_state_t        state_q, state_d;
    logic              we_q, we_d;
    mem_size_t         size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [7:0]        din_hold_q, din_hold_d;

    logic              accept;
    logic [1:0]        lane;
    logic [31:0]       ext_result;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_W];

    load_ext u_load_ext (
        .bytes_in    (buf_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext_result)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        rdata_d     = rdata_q;
        ram_wr      = 1'b0;
        ram_addr    = addr_hold_q;
        ram_din     = din_hold_q;
        done        = 1'b0;
        rdata       = rdata_q;
        // A read returns one cycle late, so the byte requested last cycle lands in lane k-1.
        lane        = cnt_q - 2'd1;
        accept      = (state_q == IDLE) && req_valid && mem_ex_signal;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    size_d  = decode_size(req_size);
                    uns_d   = req_unsigned;
                    base_d  = req_addr[ADDR_W-1:0];
                    wdata_d = req_wdata;
                    cnt_d   = 2'd0;
                    buf_d   = 32'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_addr = base_q + ADDR_W'(cnt_q);
                if (we_q) begin
                    // Suppress the write in a reset cycle so an aborted store leaves later bytes untouched.
                    ram_wr  = ~rst;
                    ram_din = wdata_q[{cnt_q, 3'b000} +: 8];
                end else if (cnt_q != 2'd0) begin
                    buf_d[{lane, 3'b000} +: 8] = ram_dout;
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == last_index(size_q)) begin
                    state_d = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                buf_d[{lane, 3'b000} +: 8] = ram_dout;
                state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (!we_q) begin
                    rdata   = ext_result;
                    rdata_d = ext_result;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        mem_stall   = (state_q == ACCESS) || (state_q == WAIT) || accept;
        addr_hold_d = ram_addr;
        din_hold_d  = ram_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= BYTE;
            uns_q       <= 1'b0;
            base_q      <= '0;
            wdata_q     <= 32'd0;
            cnt_q       <= 2'd0;
            buf_q       <= 32'd0;
            rdata_q     <= 32'd0;
            addr_hold_q <= '0;
            din_hold_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            rdata_q     <= rdata_d;
            addr_hold_q <= addr_hold_d;
            din_hold_q  <= din_hold_d;
        end
    end

endmodule
